// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
//   Shared types and default sizing for the FIFO access scheduler.
//   state_e : scheduler FSM states
//   op_e    : last FIFO operation performed, used to alternate write/read
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 4;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

endpackage

// File: rtl/fifo_access_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first requester at or after rr_ptr,
//   searching cyclically.
//   req    in  N_REQ  request vector
//   rr_ptr in  PW     highest-priority index for this cycle
//   en     in  1      when low, gnt is all zeros (sel/any still computed)
//   gnt    out N_REQ  one-hot grant
//   sel    out PW     binary index of the selected requester
//   any    out 1      at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    sel,
  output logic             any
);

  int idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any && req[idx[PW-1:0]]) begin
        any = 1'b1;
        sel = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (en && any && (int'(sel) == j)) gnt[j] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_access_sched.sv
// -----------------------------------------------------------------------------
// fifo_access_sched
//   Owns both ports of a single-ported-per-cycle FIFO: round-robin shares the
//   write port between N_REQ producers and drains the read port into a
//   valid/ready output register. FIFO write and read are never strobed in the
//   same cycle.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | may issue one write or one read (alternating under contention)
//   S_RD_WAIT | FIFO read data arriving; captured into out_data this cycle,
//             | a write may still be granted
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req, wdata          per-requester write request and data
//   gnt                 one-hot grant pulse (write of wdata[sel] this cycle)
//   out_valid/ready/data  drained-word output register
//   fifo_rst_n          FIFO reset (~rst)
//   fifo_wr, fifo_rd    FIFO strobes
//   fifo_datain         FIFO write data (0 when not writing)
//   fifo_dataout        FIFO registered read data
//   fifo_full/empty     FIFO status flags
// -----------------------------------------------------------------------------
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                fifo_rst_n,
  output logic                fifo_wr,
  output logic                fifo_rd,
  output logic [DW-1:0]       fifo_datain,
  input  logic [DW-1:0]       fifo_dataout,
  input  logic                fifo_full,
  input  logic                fifo_empty
);

  localparam int PW = $clog2(N_REQ);

  state_e        state, state_nxt;
  op_e           last_op;
  logic [PW-1:0] rr_ptr;
  logic          wr_ok, rd_ok;
  logic          do_wr, do_rd;
  logic [PW-1:0] arb_sel;
  logic          arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .en     (do_wr),
    .gnt    (gnt),
    .sel    (arb_sel),
    .any    (arb_any)
  );

  assign fifo_rst_n = ~rst;

  // Next-state and strobe decode
  always_comb begin
    state_nxt = state;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    wr_ok     = arb_any && !fifo_full;
    // Only read when the output register will have room by capture time.
    rd_ok     = !fifo_empty && (!out_valid || out_ready);

    case (state)
      S_IDLE: begin
        if (wr_ok && rd_ok) begin
          // Contention: take the opposite of whatever went last.
          if (last_op == OP_RD) do_wr = 1'b1;
          else                  do_rd = 1'b1;
        end else if (wr_ok) begin
          do_wr = 1'b1;
        end else if (rd_ok) begin
          do_rd = 1'b1;
        end
        if (do_rd) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        do_wr     = wr_ok;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (rst) begin
      do_wr = 1'b0;
      do_rd = 1'b0;
    end
  end

  assign fifo_wr = do_wr;
  assign fifo_rd = do_rd;

  always_comb begin
    fifo_datain = '0;
    if (do_wr) fifo_datain = wdata[int'(arb_sel)*DW +: DW];
  end

  // FSM state, arbitration pointer and alternation memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      last_op <= OP_RD;
    end else begin
      state <= state_nxt;
      if (do_wr) begin
        // Granted requester drops to lowest priority.
        rr_ptr  <= (int'(arb_sel) == N_REQ-1) ? '0 : arb_sel + 1'b1;
        last_op <= OP_WR;
      end else if (do_rd) begin
        last_op <= OP_RD;
      end
    end
  end

  // Output register: captured in S_RD_WAIT, held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == S_RD_WAIT) begin
      out_valid <= 1'b1;
      out_data  <= fifo_dataout;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_access_sched.sv
module tb_fifo_access_sched;
  import fifo_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        fifo_rst_n;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [3:0]  fifo_datain;
  logic [3:0]  fifo_dataout;
  logic        fifo_full;
  logic        fifo_empty;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  fifo_access_sched #(.N_REQ(4), .DW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wdata        (wdata),
    .gnt          (gnt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fifo_rst_n   (fifo_rst_n),
    .fifo_wr      (fifo_wr),
    .fifo_rd      (fifo_rd),
    .fifo_datain  (fifo_datain),
    .fifo_dataout (fifo_dataout),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] exp_gnt [5];
  logic [3:0] exp_din [5];

  initial begin
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    exp_din[0] = 4'hA; exp_din[1] = 4'hB; exp_din[2] = 4'hC;
    exp_din[3] = 4'hD; exp_din[4] = 4'hA;

    // 1: reset with all requests up and a readable FIFO
    rst = 1'b1; req = 4'b1111; wdata = 16'hDCBA; out_ready = 1'b1;
    fifo_dataout = 4'h0; fifo_full = 1'b0; fifo_empty = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_wr", 32'(fifo_wr), 0);
      chk("rst_rd", 32'(fifo_rd), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_fifo_rst_n", 32'(fifo_rst_n), 0);
    end

    // 2: round-robin rotation over all four requesters
    rst = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0;
    #1;
    chk("fifo_rst_n_release", 32'(fifo_rst_n), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_gnt[i]));
      chk($sformatf("rr_din%0d", i), 32'(fifo_datain), 32'(exp_din[i]));
      chk($sformatf("rr_rd%0d", i), 32'(fifo_rd), 0);
      if (i == 4) req = 4'b0000;
      tick();
    end
    chk("idle_datain_zero", 32'(fifo_datain), 0);

    // 3: three writes from requester 0 (rr_ptr now 1, wraps to 0), then drain
    req = 4'b0001;
    wdata = 16'h0001; #1;
    chk("w1_gnt", 32'(gnt), 32'b0001);
    chk("w1_din", 32'(fifo_datain), 1);
    tick(); wdata = 16'h0002; #1;
    chk("w2_din", 32'(fifo_datain), 2);
    tick(); wdata = 16'h0003; #1;
    chk("w3_din", 32'(fifo_datain), 3);
    tick();
    req = 4'b0000; fifo_empty = 1'b0; out_ready = 1'b1; #1;
    chk("d_rd0", 32'(fifo_rd), 1);
    chk("d_wr0", 32'(fifo_wr), 0);
    tick(); fifo_dataout = 4'h1; #1;
    chk("d_rd1", 32'(fifo_rd), 0);
    chk("d_ov1", 32'(out_valid), 0);
    tick();
    chk("d_ov2", 32'(out_valid), 1);
    chk("d_data2", 32'(out_data), 1);
    chk("d_rd2", 32'(fifo_rd), 1);
    tick(); fifo_dataout = 4'h2; #1;
    chk("d_rd3", 32'(fifo_rd), 0);
    tick();
    chk("d_data4", 32'(out_data), 2);
    chk("d_rd4", 32'(fifo_rd), 1);
    tick(); fifo_dataout = 4'h3; fifo_empty = 1'b1; #1;
    chk("d_rd5", 32'(fifo_rd), 0);
    tick();
    chk("d_ov6", 32'(out_valid), 1);
    chk("d_data6", 32'(out_data), 3);
    chk("d_rd6_empty", 32'(fifo_rd), 0);
    tick();
    chk("d_ov7_accepted", 32'(out_valid), 0);

    // 4: steady req[2] with a non-empty FIFO: strict write/read alternation
    req = 4'b0100; wdata = 16'h0700; fifo_empty = 1'b0; fifo_dataout = 4'h9; #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("alt_wr%0d", i), 32'(fifo_wr), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_rd%0d", i), 32'(fifo_rd), (i % 2 == 1) ? 1 : 0);
      chk($sformatf("alt_excl%0d", i), 32'(fifo_wr & fifo_rd), 0);
      if (i % 2 == 0) chk($sformatf("alt_gnt%0d", i), 32'(gnt), 32'b0100);
      if (i == 7) begin req = 4'b0000; fifo_empty = 1'b1; end
      tick();
    end
    tick();
    chk("alt_out_data", 32'(out_data), 9);
    tick();

    // 5: FIFO full holds off the write; grant in the cycle full drops
    fifo_full = 1'b1; req = 4'b0100; wdata = 16'h0600; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full_gnt%0d", i), 32'(gnt), 0);
      chk($sformatf("full_wr%0d", i), 32'(fifo_wr), 0);
      tick();
    end
    fifo_full = 1'b0; #1;
    chk("unfull_gnt", 32'(gnt), 32'b0100);
    chk("unfull_din", 32'(fifo_datain), 6);
    req = 4'b0000;
    tick();

    // 6: consumer stall blocks further reads and freezes out_data
    fifo_empty = 1'b0; out_ready = 1'b0; #1;
    chk("st_rd0", 32'(fifo_rd), 1);
    tick(); fifo_dataout = 4'h5;
    tick(); fifo_dataout = 4'hE;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st_ov%0d", i), 32'(out_valid), 1);
      chk($sformatf("st_data%0d", i), 32'(out_data), 5);
      chk($sformatf("st_rd%0d", i), 32'(fifo_rd), 0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("st_release_rd", 32'(fifo_rd), 1);
    tick();

    // 7: reset during the capture cycle abandons it
    chk("rw_state", 32'(dut.state), 32'(S_RD_WAIT));
    rst = 1'b1; req = 4'b1111; #1;
    chk("rw_rst_gnt", 32'(gnt), 0);
    chk("rw_rst_wr", 32'(fifo_wr), 0);
    chk("rw_fifo_rst_n", 32'(fifo_rst_n), 0);
    tick();
    chk("rw_out_valid", 32'(out_valid), 0);
    chk("rw_out_data", 32'(out_data), 0);
    chk("rw_state_idle", 32'(dut.state), 32'(S_IDLE));
    chk("rw_rr_ptr", 32'(dut.rr_ptr), 0);
    chk("rw_last_op", 32'(dut.last_op), 32'(OP_RD));
    rst = 1'b0; req = 4'b0000; fifo_empty = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
